// File: rtl/reu_pkg.sv
// Shared definitions for the REU DMA transfer sequencer.
//   - XferType encodings as carried by the register file
//   - sequencer state enum
package reu_pkg;

    typedef enum logic [1:0] {
        XFER_STASH  = 2'b00,   // C64 -> REU
        XFER_FETCH  = 2'b01,   // REU -> C64
        XFER_SWAP   = 2'b10,   // exchange, two cycles per byte
        XFER_VERIFY = 2'b11    // compare, stop on first mismatch
    } xfer_type_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_XFER,
        ST_SWAP2,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/reu_xfer_seq.sv
// reu_xfer_seq: byte-by-byte DMA sequencer between the C64 bus and SDRAM.
//
// Ports:
//   PHI2       in   C64 phase-2 clock, all state changes on rising edge
//   RESET      in   asynchronous active-high reset
//   BA         in   bus available; 0 stalls the current cycle
//   Execute    in   start request, honoured in IDLE only
//   XferType   in   2-bit transfer kind, latched on start
//   Length1    in   remaining length is 1 (current byte is the last)
//   Match      in   SDRAM read data equals C64 data bus
//   Din        in   C64 data bus
//   DMA        out  request the C64 bus
//   nWEDMA     out  C64 write strobe, active low
//   RAMRD      out  SDRAM read command
//   RAMWR      out  SDRAM write command
//   RAMWRSel   out  SDRAM write data source: 1 = HoldD, 0 = Din
//   HoldD      out  swap holding register
//   NextCA     out  advance C64 address
//   NextREUA   out  advance REU address / decrement length
//   XferEnd    out  end-of-transfer pulse
//   VerifyErr  out  verify mismatch pulse
//   Autoload   out  autoload pulse to the register file
module reu_xfer_seq
    import reu_pkg::*;
(
    input  logic       PHI2,
    input  logic       RESET,
    input  logic       BA,
    input  logic       Execute,
    input  logic [1:0] XferType,
    input  logic       Length1,
    input  logic       Match,
    input  logic [7:0] Din,
    output logic       DMA,
    output logic       nWEDMA,
    output logic       RAMRD,
    output logic       RAMWR,
    output logic       RAMWRSel,
    output logic [7:0] HoldD,
    output logic       NextCA,
    output logic       NextREUA,
    output logic       XferEnd,
    output logic       VerifyErr,
    output logic       Autoload
);

    seq_state_t state, state_nxt;
    xfer_type_t xtype;
    logic       hold_load;

    always_ff @(posedge PHI2 or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
            xtype <= XFER_STASH;
            HoldD <= 8'h00;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && Execute)
                xtype <= xfer_type_t'(XferType);
            if (hold_load)
                HoldD <= Din;
        end
    end

    // A BA-low cycle in XFER/SWAP2 issues nothing and holds state, so the
    // same cycle replays when the VIC releases the bus.
    always_comb begin
        state_nxt = state;
        hold_load = 1'b0;
        DMA       = 1'b0;
        nWEDMA    = 1'b1;
        RAMRD     = 1'b0;
        RAMWR     = 1'b0;
        RAMWRSel  = 1'b0;
        NextCA    = 1'b0;
        NextREUA  = 1'b0;
        XferEnd   = 1'b0;
        VerifyErr = 1'b0;
        Autoload  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Execute)
                    state_nxt = ST_ARB;
            end
            ST_ARB: begin
                DMA = 1'b1;
                if (BA)
                    state_nxt = ST_XFER;
            end
            ST_XFER: begin
                DMA = 1'b1;
                if (BA) begin
                    case (xtype)
                        XFER_STASH: begin
                            RAMWR    = 1'b1;
                            NextCA   = 1'b1;
                            NextREUA = 1'b1;
                        end
                        XFER_FETCH: begin
                            RAMRD    = 1'b1;
                            nWEDMA   = 1'b0;
                            NextCA   = 1'b1;
                            NextREUA = 1'b1;
                        end
                        XFER_SWAP: begin
                            // C64 byte captured now, written to SDRAM in SWAP2
                            // while the glue drives the RAM byte onto the bus.
                            RAMRD     = 1'b1;
                            hold_load = 1'b1;
                            state_nxt = ST_SWAP2;
                        end
                        XFER_VERIFY: begin
                            RAMRD = 1'b1;
                            if (Match) begin
                                NextCA   = 1'b1;
                                NextREUA = 1'b1;
                            end else begin
                                VerifyErr = 1'b1;
                                state_nxt = ST_DONE;
                            end
                        end
                        default: ;
                    endcase
                    // Byte completes on the NextREUA cycle.
                    if (NextREUA && Length1)
                        state_nxt = ST_DONE;
                end
            end
            ST_SWAP2: begin
                DMA      = 1'b1;
                RAMWRSel = 1'b1;
                if (BA) begin
                    RAMWR     = 1'b1;
                    nWEDMA    = 1'b0;
                    NextCA    = 1'b1;
                    NextREUA  = 1'b1;
                    state_nxt = Length1 ? ST_DONE : ST_XFER;
                end
            end
            ST_DONE: begin
                XferEnd   = 1'b1;
                Autoload  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_reu_xfer_seq.sv
// Self-checking bench for reu_xfer_seq. A transaction-level model expands
// each transfer (type, length, mismatch byte, BA/Din pattern) into the
// per-cycle output trace the bus should see, then the DUT is compared
// against it cycle by cycle.
module tb_reu_xfer_seq;
    import reu_pkg::*;

    logic       PHI2 = 1'b0;
    logic       RESET;
    logic       BA;
    logic       Execute;
    logic [1:0] XferType;
    logic       Length1;
    logic       Match;
    logic [7:0] Din;
    logic       DMA, nWEDMA, RAMRD, RAMWR, RAMWRSel;
    logic [7:0] HoldD;
    logic       NextCA, NextREUA, XferEnd, VerifyErr, Autoload;

    reu_xfer_seq dut (
        .PHI2(PHI2), .RESET(RESET), .BA(BA), .Execute(Execute),
        .XferType(XferType), .Length1(Length1), .Match(Match), .Din(Din),
        .DMA(DMA), .nWEDMA(nWEDMA), .RAMRD(RAMRD), .RAMWR(RAMWR),
        .RAMWRSel(RAMWRSel), .HoldD(HoldD), .NextCA(NextCA),
        .NextREUA(NextREUA), .XferEnd(XferEnd), .VerifyErr(VerifyErr),
        .Autoload(Autoload)
    );

    always #5 PHI2 = ~PHI2;

    localparam int MAXC = 256;

    int checks = 0;
    int failures = 0;

    logic       ba_a  [MAXC];
    logic       l1_a  [MAXC];
    logic       m_a   [MAXC];
    logic [7:0] din_a [MAXC];
    logic [17:0] exp_a [MAXC];
    int         ncyc;
    logic [7:0] ref_hold = 8'h00;

    // {DMA,nWEDMA,RAMRD,RAMWR,RAMWRSel,NextCA,NextREUA,XferEnd,VerifyErr,Autoload,HoldD}
    function automatic logic [17:0] pk(input logic dma, nwe, rd, wr, sel,
                                       nca, nra, xend, err, al,
                                       input logic [7:0] h);
        return {dma, nwe, rd, wr, sel, nca, nra, xend, err, al, h};
    endfunction

    function automatic logic [17:0] observed();
        return {DMA, nWEDMA, RAMRD, RAMWR, RAMWRSel, NextCA, NextREUA,
                XferEnd, VerifyErr, Autoload, HoldD};
    endfunction

    task automatic check(input string tag, input logic [17:0] exp_v);
        logic [17:0] obs;
        obs = observed();
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp_v);
        end
    endtask

    // Expand one transfer into its expected bus trace. bad = index of the
    // first mismatching byte for verify, -1 for none.
    task automatic build_model(input logic [1:0] t, input int len, input int bad);
        int  c;
        int  rem;
        bit  stop;
        bit  mt;
        logic [7:0] h;
        c = 0;
        h = ref_hold;
        stop = 0;
        // bus request: wait for BA
        do begin
            exp_a[c] = pk(1,1,0,0,0,0,0,0,0,0,h);
            l1_a[c] = (len == 1); m_a[c] = 1'b1;
            c++;
        end while (!ba_a[c-1]);
        for (int b = 0; b < len && !stop; b++) begin
            rem = len - b;
            mt = !(t == XFER_VERIFY && b == bad);
            while (!ba_a[c]) begin
                exp_a[c] = pk(1,1,0,0,0,0,0,0,0,0,h);
                l1_a[c] = (rem == 1); m_a[c] = mt;
                c++;
            end
            l1_a[c] = (rem == 1); m_a[c] = mt;
            case (t)
                XFER_STASH:  exp_a[c] = pk(1,1,0,1,0,1,1,0,0,0,h);
                XFER_FETCH:  exp_a[c] = pk(1,0,1,0,0,1,1,0,0,0,h);
                XFER_SWAP: begin
                    exp_a[c] = pk(1,1,1,0,0,0,0,0,0,0,h);
                    h = din_a[c];
                end
                default: begin
                    if (mt) exp_a[c] = pk(1,1,1,0,0,1,1,0,0,0,h);
                    else begin
                        exp_a[c] = pk(1,1,1,0,0,0,0,0,1,0,h);
                        stop = 1;
                    end
                end
            endcase
            c++;
            if (t == XFER_SWAP) begin
                while (!ba_a[c]) begin
                    exp_a[c] = pk(1,1,0,0,1,0,0,0,0,0,h);
                    l1_a[c] = (rem == 1); m_a[c] = 1'b1;
                    c++;
                end
                exp_a[c] = pk(1,0,0,1,1,1,1,0,0,0,h);
                l1_a[c] = (rem == 1); m_a[c] = 1'b1;
                c++;
            end
        end
        exp_a[c] = pk(0,1,0,0,0,0,0,1,0,1,h); l1_a[c] = 1'b0; m_a[c] = 1'b1; c++;
        exp_a[c] = pk(0,1,0,0,0,0,0,0,0,0,h); l1_a[c] = 1'b0; m_a[c] = 1'b1; c++;
        ncyc = c;
        ref_hold = h;
    endtask

    // Entered just after a rising edge with the DUT idle.
    task automatic run_xfer(input string tag, input logic [1:0] t, input int len,
                            input int bad, input bit noisy);
        build_model(t, len, bad);
        XferType = t;
        Execute = 1'b1;
        @(posedge PHI2); #1;
        Execute = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            BA = ba_a[c]; Din = din_a[c]; Length1 = l1_a[c]; Match = m_a[c];
            if (noisy) begin
                // start requests and type changes while busy must be ignored
                Execute  = (c < ncyc - 1) ? 1'($urandom) : 1'b0;
                XferType = 2'($urandom);
            end
            @(negedge PHI2);
            check($sformatf("%s_c%0d", tag, c), exp_a[c]);
            @(posedge PHI2); #1;
        end
        Execute = 1'b0;
    endtask

    task automatic fill(input bit all_ba, input logic [7:0] d);
        for (int i = 0; i < MAXC; i++) begin
            ba_a[i]  = all_ba ? 1'b1 : ((i >= 100) || ($urandom_range(0, 3) != 0));
            din_a[i] = (d == 8'h00) ? 8'($urandom) : d;
        end
    endtask

    initial begin
        int len, bad;
        logic [1:0] t;
        RESET = 1'b1; BA = 1'b1; Execute = 1'b0; XferType = 2'b00;
        Length1 = 1'b0; Match = 1'b1; Din = 8'h00;
        @(negedge PHI2);
        check("reset_state", pk(0,1,0,0,0,0,0,0,0,0,8'h00));
        @(negedge PHI2);
        RESET = 1'b0;
        @(posedge PHI2); #1;

        // stash, 3 bytes, no stalls
        fill(1, 8'h3C);
        run_xfer("stash3", XFER_STASH, 3, -1, 0);

        // fetch, 2 bytes, BA low for 2 cycles after the first byte
        fill(1, 8'h11);
        ba_a[2] = 1'b0; ba_a[3] = 1'b0;
        run_xfer("fetch2_stall", XFER_FETCH, 2, -1, 0);

        // swap, 1 byte of 8'hA5
        fill(1, 8'hA5);
        run_xfer("swap1", XFER_SWAP, 1, -1, 0);

        // verify, 4 bytes, mismatch on the second byte
        fill(1, 8'h5A);
        run_xfer("verify_err", XFER_VERIFY, 4, 1, 0);

        // stall in ARB then stash
        fill(1, 8'h77);
        ba_a[0] = 1'b0; ba_a[1] = 1'b0;
        run_xfer("arb_stall", XFER_STASH, 2, -1, 0);

        // reset during SWAP2
        BA = 1'b1; Length1 = 1'b1; Match = 1'b1; Din = 8'hC3;
        XferType = XFER_SWAP; Execute = 1'b1;
        @(posedge PHI2); #1; Execute = 1'b0;      // ARB
        @(posedge PHI2); #1;                      // XFER, captures C3
        @(posedge PHI2); #1;                      // SWAP2
        @(negedge PHI2);
        check("pre_reset_swap2", pk(1,0,0,1,1,1,1,0,0,0,8'hC3));
        RESET = 1'b1;
        #1;
        check("reset_in_swap2", pk(0,1,0,0,0,0,0,0,0,0,8'h00));
        Execute = 1'b1;
        @(posedge PHI2); @(negedge PHI2);
        check("held_reset", pk(0,1,0,0,0,0,0,0,0,0,8'h00));
        Execute = 1'b0;
        RESET = 1'b0;
        ref_hold = 8'h00;
        @(posedge PHI2); #1;
        @(negedge PHI2);
        check("idle_after_reset", pk(0,1,0,0,0,0,0,0,0,0,8'h00));
        @(posedge PHI2); #1;
        fill(1, 8'h00);
        run_xfer("restart", XFER_FETCH, 2, -1, 0);

        // randomized transfers with random stalls and bus noise
        for (int k = 0; k < 30; k++) begin
            t = 2'($urandom);
            len = $urandom_range(1, 6);
            bad = (t == XFER_VERIFY && $urandom_range(0, 1) == 1) ?
                  $urandom_range(0, len - 1) : -1;
            fill(0, 8'h00);
            run_xfer($sformatf("rnd%0d", k), t, len, bad, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
